// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//   Multi-cycle control FSM for the single-datapath CPU. It steps one
//   instruction at a time through FETCH -> DECODE -> (EXEC | MEM) -> (WB) and
//   turns the latched opcode into one-cycle datapath enables. It also owns the
//   data-memory request/acknowledge handshake.
//
// Optional feature (macro SEQ_MEM_TIMEOUT_EN):
//   When defined, the MEM state can wait at most TIMEOUT cycles for MemAck.
//   After that the FSM enters ERR and raises MemErr. When undefined, MEM waits
//   forever and there is no MemErr port.
//
// Ports:
//   CLK, RST_N   clock (rising edge), asynchronous active-low reset
//   Start        begin execution (sampled in IDLE/DONE, and ERR)
//   ProgEnd      PC is past the last instruction (sampled in FETCH)
//   Opcode       instruction opcode, captured in FETCH
//   BranchTaken  bne compare result, used in EXEC
//   MemAck       data memory finished the access (used in MEM only)
//   IRWrite, PCInc, PCBranch, RegWrite, MemReq, MemRead, MemWrite
//                one-cycle datapath enables
//   Busy         FSM is executing an instruction
//   Done         program finished (held in DONE until Start)
//   InstrCount   retired instructions since the last Start, saturating
//   MemErr       (SEQ_MEM_TIMEOUT_EN only) MEM access timed out
//   o_dbg_state  current FSM state encoding
//
// Memory handshake: MemReq is raised on MEM entry and held every MEM cycle;
// the access is complete on the first rising edge where MemReq=1 and
// MemAck=1. MemAck seen in any other state has no effect.
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int COUNT_W = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               Start,
    input  logic               ProgEnd,
    input  logic [2:0]         Opcode,
    input  logic               BranchTaken,
    input  logic               MemAck,
    output logic               IRWrite,
    output logic               PCInc,
    output logic               PCBranch,
    output logic               RegWrite,
    output logic               MemReq,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               Busy,
    output logic               Done,
`ifdef SEQ_MEM_TIMEOUT_EN
    output logic               MemErr,
`endif
    output logic [COUNT_W-1:0] InstrCount,
    output logic [2:0]         o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [2:0] OP_SB  = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_BNE = 3'd7;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_t             r_state;
    logic [2:0]         r_op;
    logic [COUNT_W-1:0] r_count;
    logic               w_retire;

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0]  r_wait;
`endif

    // An instruction retires in its last cycle: bne in EXEC, sb on the MEM
    // ack cycle, everything else in WB.
    assign w_retire = ((r_state == S_EXEC) && (r_op == OP_BNE)) ||
                      ((r_state == S_MEM) && MemAck && (r_op == OP_SB)) ||
                      (r_state == S_WB);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_op    <= 3'd0;
            r_count <= '0;
`ifdef SEQ_MEM_TIMEOUT_EN
            r_wait  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (Start) begin
                        r_state <= S_FETCH;
                        r_count <= '0;
`ifdef SEQ_MEM_TIMEOUT_EN
                        r_wait  <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    if (ProgEnd) begin
                        r_state <= S_DONE;
                    end else begin
                        r_op    <= Opcode;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if ((r_op == OP_SB) || (r_op == OP_LB)) begin
                        r_state <= S_MEM;
`ifdef SEQ_MEM_TIMEOUT_EN
                        r_wait  <= '0;
`endif
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= (r_op == OP_BNE) ? S_FETCH : S_WB;
                end
                S_MEM: begin
                    if (MemAck) begin
                        r_state <= (r_op == OP_SB) ? S_FETCH : S_WB;
                    end
`ifdef SEQ_MEM_TIMEOUT_EN
                    else if (r_wait == WAIT_W'(TIMEOUT)) begin
                        r_state <= S_ERR;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
`endif
                end
                S_WB: begin
                    r_state <= S_FETCH;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Retire never coincides with the Start-clear (different states).
            if (w_retire && (r_count != {COUNT_W{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Enables decode from the current state; FETCH and EXEC also look at the
    // live ProgEnd/BranchTaken so the strobe lands in the deciding cycle.
    always_comb begin
        IRWrite  = 1'b0;
        PCInc    = 1'b0;
        PCBranch = 1'b0;
        RegWrite = 1'b0;
        MemReq   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (r_state)
            S_FETCH: begin
                Busy    = 1'b1;
                IRWrite = ~ProgEnd;
            end
            S_DECODE: begin
                Busy = 1'b1;
            end
            S_EXEC: begin
                Busy = 1'b1;
                if (r_op == OP_BNE) begin
                    PCBranch = BranchTaken;
                    PCInc    = ~BranchTaken;
                end
            end
            S_MEM: begin
                Busy     = 1'b1;
                MemReq   = 1'b1;
                MemRead  = (r_op == OP_LB);
                MemWrite = (r_op == OP_SB);
                PCInc    = MemAck && (r_op == OP_SB);
            end
            S_WB: begin
                Busy     = 1'b1;
                RegWrite = 1'b1;
                PCInc    = 1'b1;
            end
            S_DONE: begin
                Done = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef SEQ_MEM_TIMEOUT_EN
    assign MemErr = (r_state == S_ERR);
`endif

    assign InstrCount  = r_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//   Directed bench for multicycle_sequencer. Inputs are driven on the falling
//   edge, outputs sampled 1ns later (mid-cycle) or 1ns after the rising edge.
//   A narrow COUNT_W makes InstrCount saturation reachable in a short run.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

    localparam int CW = 4;

    // State encodings of the sequencer
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_MEM   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd6;
    localparam logic [2:0] ST_ERR   = 3'd7;

    // Output vector {IRWrite,PCInc,PCBranch,RegWrite,MemReq,MemRead,MemWrite,Busy,Done}
    localparam logic [8:0] E_IDLE  = 9'b000000000;
    localparam logic [8:0] E_FETCH = 9'b100000010;
    localparam logic [8:0] E_BUSY  = 9'b000000010;
    localparam logic [8:0] E_WB    = 9'b010100010;
    localparam logic [8:0] E_BR    = 9'b001000010;
    localparam logic [8:0] E_BNT   = 9'b010000010;
    localparam logic [8:0] E_LB    = 9'b000011010;
    localparam logic [8:0] E_SBW   = 9'b000010110;
    localparam logic [8:0] E_SBA   = 9'b010010110;
    localparam logic [8:0] E_DONE  = 9'b000000001;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          Start = 1'b0;
    logic          ProgEnd = 1'b0;
    logic [2:0]    Opcode = 3'd0;
    logic          BranchTaken = 1'b0;
    logic          MemAck = 1'b0;
    logic          IRWrite, PCInc, PCBranch, RegWrite;
    logic          MemReq, MemRead, MemWrite, Busy, Done;
    logic [CW-1:0] InstrCount;
    logic [2:0]    o_dbg_state;
`ifdef SEQ_MEM_TIMEOUT_EN
    logic          MemErr;
`endif
    logic [8:0]    obs;

    int            checks = 0;
    int            failures = 0;
    logic [CW-1:0] exp_cnt = '0;

    multicycle_sequencer #(.COUNT_W(CW), .TIMEOUT(15)) dut (
        .CLK(CLK), .RST_N(RST_N), .Start(Start), .ProgEnd(ProgEnd),
        .Opcode(Opcode), .BranchTaken(BranchTaken), .MemAck(MemAck),
        .IRWrite(IRWrite), .PCInc(PCInc), .PCBranch(PCBranch),
        .RegWrite(RegWrite), .MemReq(MemReq), .MemRead(MemRead),
        .MemWrite(MemWrite), .Busy(Busy), .Done(Done),
`ifdef SEQ_MEM_TIMEOUT_EN
        .MemErr(MemErr),
`endif
        .InstrCount(InstrCount), .o_dbg_state(o_dbg_state)
    );

    assign obs = {IRWrite, PCInc, PCBranch, RegWrite, MemReq, MemRead, MemWrite, Busy, Done};

    // Clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit (failures=%0d)", failures);
        $fatal(1, "watchdog");
    end

    // Driver: set inputs for the current cycle, then settle
    task automatic drive(input logic st, input logic pe, input logic [2:0] op,
                         input logic bt, input logic ack);
        @(negedge CLK);
        Start = st; ProgEnd = pe; Opcode = op; BranchTaken = bt; MemAck = ack;
        #1;
    endtask

    task automatic model_retire();
        if (exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (obs !== E_IDLE) begin
            failures++; $display("FAIL reset_outputs: got %b want %b", obs, E_IDLE);
        end
        checks++;
        if (o_dbg_state !== ST_IDLE) begin
            failures++; $display("FAIL reset_state: got %0d want %0d", o_dbg_state, ST_IDLE);
        end
        checks++;
        if (InstrCount !== '0) begin
            failures++; $display("FAIL reset_count: got %0d want 0", InstrCount);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (o_dbg_state !== ST_IDLE || obs !== E_IDLE) begin
            failures++; $display("FAIL idle_hold: state %0d outputs %b want 0/%b", o_dbg_state, obs, E_IDLE);
        end
    endtask

    task automatic test_add();
        logic [8:0] exp_t [4];
        exp_t = '{E_FETCH, E_BUSY, E_BUSY, E_WB};
        drive(1'b1, 1'b0, 3'd2, 1'b0, 1'b0);
        checks++;
        if (obs !== E_IDLE) begin
            failures++; $display("FAIL add_idle_start: got %b want %b", obs, E_IDLE);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_t[i]) begin
                failures++; $display("FAIL add_cycle%0d: got %b want %b", i + 1, obs, exp_t[i]);
            end
        end
        model_retire();
        @(posedge CLK); #1;
        checks++;
        if (o_dbg_state !== ST_FETCH || InstrCount !== exp_cnt) begin
            failures++; $display("FAIL add_retire: state %0d count %0d want %0d/%0d",
                                 o_dbg_state, InstrCount, ST_FETCH, exp_cnt);
        end
    endtask

    // Remaining ALU opcodes; Start held high throughout must be ignored
    task automatic test_alu_ops();
        logic [8:0] exp_t [4];
        exp_t = '{E_FETCH, E_BUSY, E_BUSY, E_WB};
        for (int op = 3; op <= 6; op++) begin
            for (int i = 0; i < 4; i++) begin
                drive(1'b1, 1'b0, 3'(op), 1'b0, 1'b0);
                checks++;
                if (obs !== exp_t[i]) begin
                    failures++; $display("FAIL alu_op%0d_cycle%0d: got %b want %b", op, i + 1, obs, exp_t[i]);
                end
            end
            model_retire();
            @(posedge CLK); #1;
            checks++;
            if (o_dbg_state !== ST_FETCH || InstrCount !== exp_cnt) begin
                failures++; $display("FAIL alu_op%0d_retire: state %0d count %0d want %0d/%0d",
                                     op, o_dbg_state, InstrCount, ST_FETCH, exp_cnt);
            end
        end
        Start = 1'b0;
    endtask

    task automatic test_bne();
        logic [8:0] exp_t [3];
        for (int t = 1; t >= 0; t--) begin
            exp_t = '{E_FETCH, E_BUSY, (t == 1) ? E_BR : E_BNT};
            for (int i = 0; i < 3; i++) begin
                drive(1'b0, 1'b0, 3'd7, t[0], 1'b0);
                checks++;
                if (obs !== exp_t[i]) begin
                    failures++; $display("FAIL bne_bt%0d_cycle%0d: got %b want %b", t, i + 1, obs, exp_t[i]);
                end
            end
            model_retire();
            @(posedge CLK); #1;
            checks++;
            if (o_dbg_state !== ST_FETCH || InstrCount !== exp_cnt) begin
                failures++; $display("FAIL bne_bt%0d_retire: state %0d count %0d want %0d/%0d",
                                     t, o_dbg_state, InstrCount, ST_FETCH, exp_cnt);
            end
        end
    endtask

    // lb with two wait cycles; MemAck high in FETCH/DECODE must be ignored
    task automatic test_lb_wait();
        logic       ack_t [6];
        logic [8:0] exp_t [6];
        ack_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_t = '{E_FETCH, E_BUSY, E_LB, E_LB, E_LB, E_WB};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 3'd1, 1'b0, ack_t[i]);
            checks++;
            if (obs !== exp_t[i]) begin
                failures++; $display("FAIL lb_cycle%0d: got %b want %b", i + 1, obs, exp_t[i]);
            end
        end
        model_retire();
        @(posedge CLK); #1;
        checks++;
        if (o_dbg_state !== ST_FETCH || InstrCount !== exp_cnt) begin
            failures++; $display("FAIL lb_retire: state %0d count %0d want %0d/%0d",
                                 o_dbg_state, InstrCount, ST_FETCH, exp_cnt);
        end
    endtask

    // sb with one wait cycle, then ProgEnd -> DONE, then restart
    task automatic test_sb_done();
        logic       ack_t [4];
        logic [8:0] exp_t [4];
        ack_t = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp_t = '{E_FETCH, E_BUSY, E_SBW, E_SBA};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 3'd0, 1'b0, ack_t[i]);
            checks++;
            if (obs !== exp_t[i]) begin
                failures++; $display("FAIL sb_cycle%0d: got %b want %b", i + 1, obs, exp_t[i]);
            end
        end
        model_retire();
        drive(1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
        checks++;
        if (obs !== E_BUSY) begin
            failures++; $display("FAIL progend_fetch: got %b want %b", obs, E_BUSY);
        end
        @(posedge CLK); #1;
        checks++;
        if (o_dbg_state !== ST_DONE || obs !== E_DONE || InstrCount !== exp_cnt) begin
            failures++; $display("FAIL done_entry: state %0d outputs %b count %0d want %0d/%b/%0d",
                                 o_dbg_state, obs, InstrCount, ST_DONE, E_DONE, exp_cnt);
        end
        drive(1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
        @(posedge CLK); #1;
        checks++;
        if (o_dbg_state !== ST_DONE || obs !== E_DONE) begin
            failures++; $display("FAIL done_hold: state %0d outputs %b want %0d/%b",
                                 o_dbg_state, obs, ST_DONE, E_DONE);
        end
        drive(1'b1, 1'b0, 3'd7, 1'b0, 1'b0);
        exp_cnt = '0;
        @(posedge CLK); #1;
        Start = 1'b0;
        checks++;
        if (o_dbg_state !== ST_FETCH || InstrCount !== exp_cnt) begin
            failures++; $display("FAIL restart: state %0d count %0d want %0d/0",
                                 o_dbg_state, InstrCount, ST_FETCH);
        end
    endtask

    // 17 not-taken bne instructions: counter must stop at all-ones
    task automatic test_saturation();
        for (int n = 0; n < 17; n++) begin
            repeat (3) drive(1'b0, 1'b0, 3'd7, 1'b0, 1'b0);
            model_retire();
            @(posedge CLK); #1;
            checks++;
            if (InstrCount !== exp_cnt) begin
                failures++; $display("FAIL saturate_n%0d: got %0d want %0d", n + 1, InstrCount, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        drive(1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        checks++;
        if (o_dbg_state !== ST_MEM || obs !== E_LB) begin
            failures++; $display("FAIL mem_wait_before_reset: state %0d outputs %b want %0d/%b",
                                 o_dbg_state, obs, ST_MEM, E_LB);
        end
        RST_N = 1'b0;
        #1;
        checks++;
        if (obs !== E_IDLE || o_dbg_state !== ST_IDLE || InstrCount !== '0) begin
            failures++; $display("FAIL async_abort: outputs %b state %0d count %0d want 0/0/0",
                                 obs, o_dbg_state, InstrCount);
        end
        MemAck = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (obs !== E_IDLE) begin
            failures++; $display("FAIL reset_held_ack: got %b want %b", obs, E_IDLE);
        end
        @(negedge CLK);
        RST_N = 1'b1; MemAck = 1'b0;
        exp_cnt = '0;
        @(posedge CLK); #1;
        checks++;
        if (o_dbg_state !== ST_IDLE || obs !== E_IDLE || InstrCount !== exp_cnt) begin
            failures++; $display("FAIL after_release: state %0d outputs %b count %0d want 0/0/0",
                                 o_dbg_state, obs, InstrCount);
        end
    endtask

`ifdef SEQ_MEM_TIMEOUT_EN
    task automatic test_timeout();
        drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
            checks++;
            if (obs !== E_SBW || MemErr !== 1'b0) begin
                failures++; $display("FAIL timeout_mem%0d: outputs %b err %b want %b/0", i + 1, obs, MemErr, E_SBW);
            end
        end
        @(posedge CLK); #1;
        checks++;
        if (o_dbg_state !== ST_ERR || MemErr !== 1'b1 || obs !== E_IDLE) begin
            failures++; $display("FAIL timeout_err: state %0d err %b outputs %b want %0d/1/0",
                                 o_dbg_state, MemErr, obs, ST_ERR);
        end
        drive(1'b1, 1'b0, 3'd2, 1'b0, 1'b0);
        @(posedge CLK); #1;
        Start = 1'b0;
        checks++;
        if (o_dbg_state !== ST_FETCH || MemErr !== 1'b0 || InstrCount !== '0) begin
            failures++; $display("FAIL timeout_resume: state %0d err %b count %0d want %0d/0/0",
                                 o_dbg_state, MemErr, InstrCount, ST_FETCH);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_bne();
        test_lb_wait();
        test_sb_done();
        test_saturation();
        test_reset_mid_mem();
`ifdef SEQ_MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
